// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock feedback scheduler: FSM states,
// matrix/buzzer codes and LED bar patterns.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OK_SWEEP,
        CHG_HOLD,
        ERR,
        LOCKOUT
    } state_t;

    localparam logic [1:0] LS_IDLE  = 2'd0;
    localparam logic [1:0] LS_OPEN  = 2'd1;
    localparam logic [1:0] LS_SETUP = 2'd2;
    localparam logic [1:0] LS_ALARM = 2'd3;

    localparam logic [1:0] TONE_SILENT = 2'd0;
    localparam logic [1:0] TONE_OK     = 2'd1;
    localparam logic [1:0] TONE_ERR    = 2'd2;
    localparam logic [1:0] TONE_ALARM  = 2'd3;

    localparam logic [7:0] PAT_ALT  = 8'hAA;
    localparam logic [7:0] PAT_FULL = 8'hFF;

    // Sweep bar for step k: k low bits lit, dark for k==0 or k>8.
    function automatic logic [7:0] bar_fill(input logic [3:0] k);
        logic [8:0] m;
        m = (9'd1 << k) - 9'd1;
        return (k > 4'd8) ? 8'h00 : m[7:0];
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high for the last cycle of a loaded interval,
// so a load of N followed by a transition on done occupies exactly N cycles.
module cycle_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cnt <= '0;
        else if (load)       cnt <= value;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/indicator_scheduler.sv
// Arbitrates wrong-password / unlock / password-changed events and plays the
// matching LED, matrix, blink and buzzer sequence, including failure lockout.
module indicator_scheduler
    import lock_pkg::*;
#(
    parameter int STEP_CYCLES = 10240,
    parameter int CHG_CYCLES  = 51200,
    parameter int ERR_CYCLES  = 20480,
    parameter int LOCK_CYCLES = 204800,
    parameter int MAX_FAIL    = 3,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_fail,
    input  logic       req_ok,
    input  logic       req_chg,
    output logic       ack_fail,
    output logic       ack_ok,
    output logic       ack_chg,
    output logic [7:0] LED,
    output logic       blink,
    output logic [1:0] led_state,
    output logic [1:0] tone,
    output logic       busy,
    output logic       locked,
    output logic [1:0] fail_cnt
);

    state_t           state, next_state;
    logic             grant_fail, grant_ok, grant_chg, entering;
    logic             dur_done, step_done, dur_load, step_load;
    logic [CNT_W-1:0] dur_value;
    logic [3:0]       step_q, step_d;
    logic [7:0]       led_d;
    logic             blink_d;
    logic [1:0]       ls_d, tone_d, fail_d;

    assign grant_fail = (state == IDLE) && req_fail;
    assign grant_ok   = (state == IDLE) && !req_fail && req_ok;
    assign grant_chg  = (state == IDLE) && !req_fail && !req_ok && req_chg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step_q    <= '0;
            LED       <= '0;
            blink     <= 1'b0;
            led_state <= LS_IDLE;
            tone      <= TONE_SILENT;
            busy      <= 1'b0;
            locked    <= 1'b0;
            fail_cnt  <= '0;
            ack_fail  <= 1'b0;
            ack_ok    <= 1'b0;
            ack_chg   <= 1'b0;
        end else begin
            state     <= next_state;
            step_q    <= step_d;
            LED       <= led_d;
            blink     <= blink_d;
            led_state <= ls_d;
            tone      <= tone_d;
            busy      <= (next_state != IDLE);
            locked    <= (next_state == LOCKOUT);
            fail_cnt  <= fail_d;
            ack_fail  <= grant_fail;
            ack_ok    <= grant_ok;
            ack_chg   <= grant_chg;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_fail)     next_state = ERR;
                else if (grant_ok)  next_state = OK_SWEEP;
                else if (grant_chg) next_state = CHG_HOLD;
            end
            OK_SWEEP, CHG_HOLD, LOCKOUT: if (dur_done) next_state = IDLE;
            ERR: if (dur_done)
                next_state = (fail_cnt == 2'(MAX_FAIL)) ? LOCKOUT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Every non-IDLE state reloads the duration timer on entry; the step timer
    // free-runs with auto-reload while sweeping or alternating.
    assign entering  = (next_state != state);
    assign dur_load  = entering && (next_state != IDLE);
    assign step_load = (entering && (next_state == OK_SWEEP || next_state == ERR)) ||
                       (step_done && (state == OK_SWEEP || state == ERR));

    always_comb begin
        dur_value = '0;
        case (next_state)
            OK_SWEEP: dur_value = CNT_W'(10 * STEP_CYCLES);
            CHG_HOLD: dur_value = CNT_W'(CHG_CYCLES);
            ERR:      dur_value = CNT_W'(ERR_CYCLES);
            LOCKOUT:  dur_value = CNT_W'(LOCK_CYCLES);
            default:  dur_value = '0;
        endcase
    end

    cycle_timer #(.CNT_W(CNT_W)) u_dur_timer (
        .clk   (clk),
        .reset (reset),
        .load  (dur_load),
        .value (dur_value),
        .done  (dur_done)
    );

    cycle_timer #(.CNT_W(CNT_W)) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .load  (step_load),
        .value (CNT_W'(STEP_CYCLES)),
        .done  (step_done)
    );

    always_comb begin
        led_d   = '0;
        blink_d = 1'b0;
        ls_d    = LS_IDLE;
        tone_d  = TONE_SILENT;
        step_d  = step_q;
        case (next_state)
            OK_SWEEP: begin
                blink_d = 1'b1;
                ls_d    = LS_OPEN;
                tone_d  = TONE_OK;
                if (entering) begin
                    step_d = '0;
                    led_d  = '0;
                end else if (step_done) begin
                    step_d = step_q + 4'd1;
                    led_d  = bar_fill(step_d);
                end else begin
                    led_d  = LED;
                end
            end
            CHG_HOLD: begin
                blink_d = 1'b1;
                ls_d    = LS_SETUP;
                tone_d  = TONE_OK;
            end
            ERR: begin
                ls_d   = LS_ALARM;
                tone_d = TONE_ERR;
                if (entering)       led_d = PAT_ALT;
                else if (step_done) led_d = ~LED;
                else                led_d = LED;
            end
            LOCKOUT: begin
                blink_d = 1'b1;
                ls_d    = LS_ALARM;
                tone_d  = TONE_ALARM;
                led_d   = PAT_FULL;
            end
            default: ;
        endcase
    end

    always_comb begin
        fail_d = fail_cnt;
        if (grant_ok)
            fail_d = '0;
        else if (grant_fail && fail_cnt != 2'(MAX_FAIL))
            fail_d = fail_cnt + 2'd1;
        else if (state == LOCKOUT && dur_done)
            fail_d = '0;
    end

endmodule

// File: tb/tb_indicator_scheduler.sv
// Directed bench for indicator_scheduler: stimulus queues the expected grant
// response, a monitor pops it whenever an ack appears; timing checks are inline.
module tb_indicator_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_fail = 1'b0, req_ok = 1'b0, req_chg = 1'b0;
    logic       ack_fail, ack_ok, ack_chg;
    logic [7:0] LED;
    logic       blink, busy, locked;
    logic [1:0] led_state, tone, fail_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] ack;
        logic [1:0] fcnt;
        logic [1:0] tone;
        logic [1:0] ls;
        logic       blink;
    } exp_t;

    exp_t sb[$];

    indicator_scheduler #(
        .STEP_CYCLES(4), .CHG_CYCLES(8), .ERR_CYCLES(8),
        .LOCK_CYCLES(16), .MAX_FAIL(3), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .req_fail(req_fail), .req_ok(req_ok), .req_chg(req_chg),
        .ack_fail(ack_fail), .ack_ok(ack_ok), .ack_chg(ack_chg),
        .LED(LED), .blink(blink), .led_state(led_state), .tone(tone),
        .busy(busy), .locked(locked), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sweep(input int k);
        return (k >= 1 && k <= 8) ? (8'hFF >> (8 - k)) : 8'h00;
    endfunction

    // which: 0 fail, 1 ok, 2 chg; drops the request the cycle the ack is seen
    task automatic wait_ack(input int which, input int budget);
        logic seen = 1'b0;
        logic [2:0] acks;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            acks = {ack_fail, ack_ok, ack_chg};
            if (acks[2-which]) seen = 1'b1;
        end
        chk($sformatf("ack_wait_%0d", which), 32'(seen), 32'd1);
        case (which)
            0: req_fail = 1'b0;
            1: req_ok   = 1'b0;
            default: req_chg = 1'b0;
        endcase
    endtask

    task automatic wait_idle(input int budget);
        logic idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk("idle_wait", 32'(idle), 32'd1);
    endtask

    task automatic push(input logic [2:0] a, input logic [1:0] f, input logic [1:0] t,
                        input logic [1:0] l, input logic b);
        exp_t e;
        e.ack = a; e.fcnt = f; e.tone = t; e.ls = l; e.blink = b;
        sb.push_back(e);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack_fail || ack_ok || ack_chg) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", {29'd0, ack_fail, ack_ok, ack_chg}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ack",   {29'd0, ack_fail, ack_ok, ack_chg}, 32'(e.ack));
                    chk("sb_fcnt",  32'(fail_cnt),  32'(e.fcnt));
                    chk("sb_tone",  32'(tone),      32'(e.tone));
                    chk("sb_ls",    32'(led_state), 32'(e.ls));
                    chk("sb_blink", 32'(blink),     32'(e.blink));
                    chk("sb_busy",  32'(busy),      32'd1);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outs", {11'd0, ack_fail, ack_ok, ack_chg, LED, blink, led_state, tone,
                           busy, locked, fail_cnt}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: unlock sweep timing
        push(3'b010, 2'd0, 2'd1, 2'd1, 1'b1);
        req_ok = 1'b1;
        wait_ack(1, 5);
        for (int k = 1; k <= 9; k++) begin
            repeat (4) @(negedge clk);
            chk($sformatf("sweep_led_%0d", k), 32'(LED), 32'(sweep(k)));
            chk($sformatf("sweep_tl_%0d", k), {28'd0, tone, led_state}, 32'h5);
        end
        repeat (3) @(negedge clk);
        chk("sweep_busy_39", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sweep_end_40", {20'd0, busy, LED, tone}, 32'd0);

        // 2: simultaneous requests, fixed priority
        push(3'b100, 2'd1, 2'd2, 2'd3, 1'b0);
        push(3'b010, 2'd0, 2'd1, 2'd1, 1'b1);
        push(3'b001, 2'd0, 2'd1, 2'd2, 1'b1);
        req_fail = 1'b1; req_ok = 1'b1; req_chg = 1'b1;
        wait_ack(0, 5);
        chk("err_led_start", 32'(LED), 32'hAA);
        repeat (4) @(negedge clk);
        chk("err_led_alt", 32'(LED), 32'h55);
        wait_ack(1, 20);
        wait_ack(2, 60);
        wait_idle(20);

        // 3+4: three failures, lockout, ok pending during lockout
        push(3'b100, 2'd1, 2'd2, 2'd3, 1'b0);
        req_fail = 1'b1; wait_ack(0, 5); wait_idle(20);
        push(3'b100, 2'd2, 2'd2, 2'd3, 1'b0);
        req_fail = 1'b1; wait_ack(0, 5); wait_idle(20);
        push(3'b100, 2'd3, 2'd2, 2'd3, 1'b0);
        req_fail = 1'b1; wait_ack(0, 5);
        repeat (8) @(negedge clk);
        chk("lock_outs", {19'd0, locked, tone, led_state, blink, LED}, {19'd0, 1'b1, 2'd3, 2'd3, 1'b1, 8'hFF});
        push(3'b010, 2'd0, 2'd1, 2'd1, 1'b1);
        req_ok = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("lock_hold_%0d", i), {30'd0, locked, ack_ok}, 32'h2);
        end
        @(negedge clk);
        chk("lock_end", {27'd0, locked, busy, ack_ok, fail_cnt}, 32'd0);
        @(negedge clk);
        chk("lock_ack_ok", 32'(ack_ok), 32'd1);
        req_ok = 1'b0;
        wait_idle(50);

        // 5: password changed keeps fail count
        push(3'b100, 2'd1, 2'd2, 2'd3, 1'b0);
        req_fail = 1'b1; wait_ack(0, 5); wait_idle(20);
        push(3'b100, 2'd2, 2'd2, 2'd3, 1'b0);
        req_fail = 1'b1; wait_ack(0, 5); wait_idle(20);
        push(3'b001, 2'd2, 2'd1, 2'd2, 1'b1);
        req_chg = 1'b1; wait_ack(2, 5);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("chg_hold_%0d", i), {19'd0, blink, led_state, LED, fail_cnt},
                {19'd0, 1'b1, 2'd2, 8'h00, 2'd2});
            @(negedge clk);
        end
        chk("chg_end", {29'd0, busy, fail_cnt}, 32'h2);

        // 6: async reset mid-sweep
        push(3'b010, 2'd0, 2'd1, 2'd1, 1'b1);
        req_ok = 1'b1; wait_ack(1, 5);
        repeat (12) @(negedge clk);
        chk("pre_reset_led", 32'(LED), 32'h07);
        #2 reset = 1'b0;
        #1 chk("async_reset", {11'd0, ack_fail, ack_ok, ack_chg, LED, blink, led_state, tone,
                               busy, locked, fail_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", {30'd0, busy, ack_ok}, 32'd0);
        push(3'b001, 2'd0, 2'd1, 2'd2, 1'b1);
        req_chg = 1'b1; wait_ack(2, 5); wait_idle(20);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/indicator_scheduler.md
Name: indicator_scheduler

Overview:
- Sequences the door lock's shared feedback resources: LED bar, display blink flag, LED-matrix pattern code and buzzer tone code.
- Three event requesters use a req/ack handshake: wrong password, unlock success and password changed. The main lock FSM is the usual source.
- A fixed-priority arbiter grants one event at a time and plays its timed indicator sequence.
- Counts consecutive wrong-password events and enforces a timed lockout.

Parameters:
- STEP_CYCLES, 10240, clk cycles per LED sweep/alternate step
- CHG_CYCLES, 51200, clk cycles of the password-changed indication
- ERR_CYCLES, 20480, clk cycles of the wrong-password indication
- LOCK_CYCLES, 204800, clk cycles of lockout
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..3)
- CNT_W, 32, cycle counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_fail  in  1  wrong-password event request (level, held until ack)
- req_ok  in  1  unlock-success event request
- req_chg  in  1  password-changed event request
- ack_fail  out  1  one-cycle grant pulse
- ack_ok  out  1  one-cycle grant pulse
- ack_chg  out  1  one-cycle grant pulse
- LED  out  8  LED bar
- blink  out  1  seven-segment blink enable
- led_state  out  2  matrix pattern: 0 idle, 1 open, 2 setup/changed, 3 alarm
- tone  out  2  buzzer code: 0 silent, 1 success, 2 error, 3 alarm
- busy  out  1  high in every state except IDLE
- locked  out  1  high during lockout
- fail_cnt  out  2  consecutive failure count

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, counters 0. Reset mid-sequence aborts the sequence immediately. Pending requests are not remembered.
- All outputs are registered.
- IDLE: outputs 0 except fail_cnt. Arbitration runs only here; priority is fail > ok > chg.
- Grant: the ack for the winner pulses for exactly 1 cycle. Next state is entered on the same edge. busy=1 from that cycle.
- Requester rule: deassert req the cycle after ack. A req still high after its sequence ends is treated as a new event.
- Non-granted requests stay pending (not acked) until a later IDLE.
- OK_SWEEP: on grant, fail_cnt<=0. blink=1, led_state=1, tone=1.
  - A step counter advances every STEP_CYCLES.
  - LED after step k (k=1..8) = k low bits set, 00000001 through 11111111. After step 9 LED=0.
  - After step 10 → IDLE with all outputs cleared.
  - Total duration 10*STEP_CYCLES cycles after grant.
- CHG_HOLD: blink=1, led_state=2, tone=1, LED=0. Lasts CHG_CYCLES cycles → IDLE. fail_cnt unchanged.
- ERR: on grant, fail_cnt<=fail_cnt+1, saturating at MAX_FAIL. tone=2, led_state=3, blink=0.
  - LED starts at 8'hAA and inverts every STEP_CYCLES.
  - After ERR_CYCLES cycles: → LOCKOUT if fail_cnt==MAX_FAIL, else → IDLE.
- LOCKOUT: locked=1, tone=3, led_state=3, blink=1, LED=8'hFF.
  - No requests acked; all remain pending.
  - After LOCK_CYCLES cycles: fail_cnt<=0, locked<=0, → IDLE.
- Durations are exact: the state is occupied for the stated cycle count, with the counter reloaded on entry.
- A counter wraps only via reload, never by overflow. Parameters must fit CNT_W.
- Simultaneous requests in IDLE: only the highest-priority request is acked that cycle.

Decomposition:
- Shared package lock_pkg holds:
  - the state enumeration (IDLE, OK_SWEEP, CHG_HOLD, ERR, LOCKOUT)
  - led_state codes
  - tone codes
  - pattern constants 8'hAA and 8'hFF
- One sub-module, cycle_timer: a CNT_W-bit loadable down-counter with load/value inputs and a done pulse. It is instanced twice, once for sequence duration and once for step cadence.

Test Plan:
All scenarios use STEP_CYCLES=4, CHG_CYCLES=8, ERR_CYCLES=8, LOCK_CYCLES=16, MAX_FAIL=3.
- Reset release, then req_ok → ack_ok 1 cycle; LED reads 01,03,07,…,FF at 4-cycle steps, then 00; busy low exactly 40 cycles after grant; tone=1, led_state=1 throughout.
- req_fail, req_ok, req_chg raised in the same cycle → ack_fail first; then ack_ok at the first IDLE after ERR; then ack_chg after the sweep; fail_cnt goes 1 then 0.
- Three req_fail events in sequence → fail_cnt 1,2,3; after the third ERR, locked=1 and tone=3 for 16 cycles; then fail_cnt=0, locked=0.
- req_ok asserted during LOCKOUT → no ack until lockout ends; ack_ok in the first IDLE cycle.
- req_chg → blink=1, led_state=2 for 8 cycles; LED=0; fail_cnt unchanged from prior value 2.
- reset pulled low mid-OK_SWEEP (LED=07) → all outputs 0 asynchronously; after release, IDLE with no ack until a new req.
